// File: rtl/div_req_ctrl.sv
// Issue-side controller for the radix-2 divider: request FIFO, single-outstanding
// dispatch, result capture for writeback, flush handling and a sticky protocol flag.
package div_req_ctrl_pkg;
  localparam int TRANS_ID_BITS = 3;
  typedef enum logic [3:0] {
    DIV, DIVU, DIVW, DIVUW, REM, REMU, REMW, REMUW
  } fu_op;
endpackage

module div_req_ctrl
  import div_req_ctrl_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     issue_valid_i,
  output logic                     issue_ready_o,
  input  logic [TRANS_ID_BITS-1:0] issue_trans_id_i,
  input  fu_op                     issue_operator_i,
  input  logic [63:0]              issue_operand_a_i,
  input  logic [63:0]              issue_operand_b_i,
  output logic                     div_valid_o,
  input  logic                     div_ready_i,
  output logic [TRANS_ID_BITS-1:0] div_trans_id_o,
  output fu_op                     div_operator_o,
  output logic [63:0]              div_operand_a_o,
  output logic [63:0]              div_operand_b_o,
  input  logic                     div_valid_i,
  input  logic [63:0]              div_result_i,
  input  logic [TRANS_ID_BITS-1:0] div_trans_id_i,
  output logic                     wb_valid_o,
  input  logic                     wb_ready_i,
  output logic [TRANS_ID_BITS-1:0] wb_trans_id_o,
  output logic [63:0]              wb_result_o,
  output logic                     busy_o,
  output logic                     protocol_err_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [TRANS_ID_BITS-1:0] trans_id;
    fu_op                     op;
    logic [63:0]              a;
    logic [63:0]              b;
  } entry_t;

  typedef enum logic [2:0] {IDLE, REQ, WAIT, RESP, DRAIN} state_e;

  entry_t                   mem [DEPTH];
  logic [PTR_W-1:0]         wr_ptr_reg;
  logic [PTR_W-1:0]         rd_ptr_reg;
  logic [CNT_W-1:0]         count_reg;
  logic [CNT_W-1:0]         count_next;
  state_e                   state_reg;
  logic [TRANS_ID_BITS-1:0] inflight_id_reg;
  logic                     full;
  logic                     push;
  logic                     pop;
  logic                     q_nonempty_next;
  logic                     result_expected;
  logic                     unexpected_result;
  entry_t                   issue_entry;
  entry_t                   head_entry;

  assign full          = (count_reg == CNT_W'(DEPTH));
  assign issue_ready_o = rst_ni & ~flush_i & ~full;
  assign push          = issue_valid_i & issue_ready_o;
  assign pop           = div_valid_o & div_ready_i;

  assign count_next      = flush_i ? '0 : count_reg + CNT_W'(push) - CNT_W'(pop);
  assign q_nonempty_next = (count_next != '0);

  assign issue_entry = '{trans_id: issue_trans_id_i, op: issue_operator_i,
                         a: issue_operand_a_i, b: issue_operand_b_i};
  // An empty queue being written this cycle forwards the incoming request.
  assign head_entry  = (count_reg == '0) ? issue_entry : mem[rd_ptr_reg];

  assign result_expected   = (state_reg == WAIT) || (state_reg == DRAIN);
  assign unexpected_result = div_valid_i &
                             (~result_expected | (div_trans_id_i != inflight_id_reg));

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr_reg] <= issue_entry;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      count_reg <= count_next;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_reg       <= IDLE;
      div_valid_o     <= 1'b0;
      div_trans_id_o  <= '0;
      div_operator_o  <= DIV;
      div_operand_a_o <= '0;
      div_operand_b_o <= '0;
      wb_valid_o      <= 1'b0;
      wb_trans_id_o   <= '0;
      wb_result_o     <= '0;
      inflight_id_reg <= '0;
      busy_o          <= 1'b0;
      protocol_err_o  <= 1'b0;
    end else begin
      busy_o <= 1'b1;
      if (unexpected_result) protocol_err_o <= 1'b1;
      case (state_reg)
        IDLE: begin
          if (!flush_i && count_reg != '0) begin
            state_reg       <= REQ;
            div_valid_o     <= 1'b1;
            div_trans_id_o  <= head_entry.trans_id;
            div_operator_o  <= head_entry.op;
            div_operand_a_o <= head_entry.a;
            div_operand_b_o <= head_entry.b;
          end else begin
            busy_o <= q_nonempty_next;
          end
        end
        REQ: begin
          if (div_ready_i) begin
            div_valid_o     <= 1'b0;
            inflight_id_reg <= div_trans_id_o;
            state_reg       <= flush_i ? DRAIN : WAIT;
          end else if (flush_i) begin
            div_valid_o <= 1'b0;
            state_reg   <= IDLE;
            busy_o      <= q_nonempty_next;
          end
        end
        WAIT: begin
          // A result landing in the flush cycle is already consumed; no drain needed.
          if (div_valid_i && flush_i) begin
            state_reg <= IDLE;
            busy_o    <= q_nonempty_next;
          end else if (div_valid_i) begin
            wb_valid_o    <= 1'b1;
            wb_result_o   <= div_result_i;
            wb_trans_id_o <= div_trans_id_i;
            state_reg     <= RESP;
          end else if (flush_i) begin
            state_reg <= DRAIN;
          end
        end
        RESP: begin
          if (flush_i) begin
            wb_valid_o <= 1'b0;
            state_reg  <= IDLE;
            busy_o     <= q_nonempty_next;
          end else if (wb_ready_i) begin
            wb_valid_o <= 1'b0;
            if (q_nonempty_next) begin
              state_reg       <= REQ;
              div_valid_o     <= 1'b1;
              div_trans_id_o  <= head_entry.trans_id;
              div_operator_o  <= head_entry.op;
              div_operand_a_o <= head_entry.a;
              div_operand_b_o <= head_entry.b;
            end else begin
              state_reg <= IDLE;
              busy_o    <= q_nonempty_next;
            end
          end
        end
        DRAIN: begin
          if (div_valid_i) begin
            state_reg <= IDLE;
            busy_o    <= q_nonempty_next;
          end
        end
        default: begin
          state_reg   <= IDLE;
          div_valid_o <= 1'b0;
          wb_valid_o  <= 1'b0;
          busy_o      <= q_nonempty_next;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_div_req_ctrl.sv
// Bench for div_req_ctrl: table of divider requests with constant expected results,
// a behavioural divider, scoreboards on the divider and writeback sides.
module tb_div_req_ctrl;
  import div_req_ctrl_pkg::*;
  localparam int IDW = TRANS_ID_BITS;

  logic           clk = 1'b0;
  logic           rst_ni, flush_i, issue_valid_i, issue_ready_o;
  logic [IDW-1:0] issue_trans_id_i, div_trans_id_o, div_trans_id_i, wb_trans_id_o;
  fu_op           issue_operator_i, div_operator_o;
  logic [63:0]    issue_operand_a_i, issue_operand_b_i, div_operand_a_o, div_operand_b_o;
  logic           div_valid_o, div_ready_i, div_valid_i, wb_valid_o, wb_ready_i;
  logic [63:0]    div_result_i, wb_result_o;
  logic           busy_o, protocol_err_o;

  always #5 clk = ~clk;

  div_req_ctrl #(.DEPTH(2)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .issue_trans_id_i(issue_trans_id_i), .issue_operator_i(issue_operator_i),
    .issue_operand_a_i(issue_operand_a_i), .issue_operand_b_i(issue_operand_b_i),
    .div_valid_o(div_valid_o), .div_ready_i(div_ready_i), .div_trans_id_o(div_trans_id_o),
    .div_operator_o(div_operator_o), .div_operand_a_o(div_operand_a_o),
    .div_operand_b_o(div_operand_b_o), .div_valid_i(div_valid_i),
    .div_result_i(div_result_i), .div_trans_id_i(div_trans_id_i),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_trans_id_o(wb_trans_id_o),
    .wb_result_o(wb_result_o), .busy_o(busy_o), .protocol_err_o(protocol_err_o)
  );

  typedef struct { fu_op op; logic [63:0] a; logic [63:0] b; logic [IDW-1:0] id; logic [63:0] res; } vec_t;
  typedef struct { logic [IDW-1:0] id; fu_op op; logic [63:0] a; logic [63:0] b; } dreq_t;
  typedef struct { logic [IDW-1:0] id; logic [63:0] res; } wbexp_t;

  vec_t   tbl [8];
  dreq_t  exp_div_q [$];
  wbexp_t exp_wb_q [$];
  int     checks = 0, failures = 0, xfer_count = 0, wb_count = 0;
  int     div_lat = 3;
  logic   bad_id = 1'b0, force_pulse = 1'b0, mdl_busy = 1'b0;
  int     mdl_cnt = 0;
  logic [63:0]    mdl_res = '0;
  logic [IDW-1:0] mdl_id = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Reference behaviour of the divider itself (RISC-V M semantics).
  function automatic logic [63:0] div_model(input fu_op op, input logic [63:0] a, input logic [63:0] b);
    logic signed [63:0] sa, sb;
    logic signed [31:0] wa, wb;
    logic [31:0] r32;
    logic ovf64, ovf32;
    sa = a; sb = b; wa = a[31:0]; wb = b[31:0];
    ovf64 = (a == 64'h8000_0000_0000_0000) && (b == '1);
    ovf32 = (a[31:0] == 32'h8000_0000) && (b[31:0] == '1);
    r32 = '0;
    case (op)
      DIV:  if (b == 0) return '1; else if (ovf64) return a; else return sa / sb;
      DIVU: if (b == 0) return '1; else return a / b;
      REM:  if (b == 0) return a; else if (ovf64) return '0; else return sa % sb;
      REMU: if (b == 0) return a; else return a % b;
      DIVW:  if (b[31:0] == 0) r32 = '1; else if (ovf32) r32 = a[31:0]; else r32 = wa / wb;
      DIVUW: if (b[31:0] == 0) r32 = '1; else r32 = a[31:0] / b[31:0];
      REMW:  if (b[31:0] == 0) r32 = a[31:0]; else if (ovf32) r32 = '0; else r32 = wa % wb;
      default: if (b[31:0] == 0) r32 = a[31:0]; else r32 = a[31:0] % b[31:0];
    endcase
    return {{32{r32[31]}}, r32};
  endfunction

  // Behavioural divider: one-cycle result pulse div_lat cycles after the transfer.
  initial begin
    div_valid_i = 1'b0; div_result_i = '0; div_trans_id_i = '0;
    forever begin
      @(posedge clk); #1;
      div_valid_i = 1'b0;
      if (force_pulse) begin
        div_valid_i = 1'b1; div_trans_id_i = '0; div_result_i = '0; force_pulse = 1'b0;
      end else if (mdl_busy) begin
        if (mdl_cnt == 0) begin
          div_valid_i = 1'b1; div_result_i = mdl_res; div_trans_id_i = mdl_id; mdl_busy = 1'b0;
        end else mdl_cnt--;
      end
    end
  end

  // Monitors: handshakes are visible at the falling edge and complete on the next rising edge.
  initial begin
    dreq_t  d;
    wbexp_t w;
    forever begin
      @(negedge clk);
      if (rst_ni && div_valid_o && div_ready_i) begin
        xfer_count++;
        check("one_in_flight", {63'b0, mdl_busy | wb_valid_o}, 64'd0);
        if (exp_div_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL div_unexpected: transfer id=%0d, required none", div_trans_id_o);
        end else begin
          d = exp_div_q.pop_front();
          check("div_id", div_trans_id_o, d.id);
          check("div_op", div_operator_o, d.op);
          check("div_a", div_operand_a_o, d.a);
          check("div_b", div_operand_b_o, d.b);
        end
        mdl_busy = 1'b1; mdl_cnt = div_lat;
        mdl_res  = div_model(div_operator_o, div_operand_a_o, div_operand_b_o);
        mdl_id   = bad_id ? (div_trans_id_o ^ IDW'(1)) : div_trans_id_o;
      end
      if (rst_ni && wb_valid_o && wb_ready_i) begin
        wb_count++;
        $display("wb id=%0d result=%h", wb_trans_id_o, wb_result_o);
        if (exp_wb_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL wb_unexpected: id=%0d result=%h, required none", wb_trans_id_o, wb_result_o);
        end else begin
          w = exp_wb_q.pop_front();
          check("wb_id", wb_trans_id_o, w.id);
          check("wb_result", wb_result_o, w.res);
        end
      end
    end
  end

  task automatic issue(input vec_t v, input logic [IDW-1:0] wb_id);
    int n = 0;
    logic ok = 1'b0;
    @(posedge clk); #1;
    issue_valid_i = 1'b1; issue_trans_id_i = v.id; issue_operator_i = v.op;
    issue_operand_a_i = v.a; issue_operand_b_i = v.b;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = issue_ready_o;
      n++;
    end
    if (ok) begin
      exp_div_q.push_back('{id: v.id, op: v.op, a: v.a, b: v.b});
      exp_wb_q.push_back('{id: wb_id, res: v.res});
    end else begin
      checks++; failures++;
      $display("FAIL issue_timeout: id=%0d not accepted, required accept", v.id);
    end
    @(posedge clk); #1;
    issue_valid_i = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    do begin @(negedge clk); n++; end while ((exp_wb_q.size() != 0 || busy_o) && n < 300);
    checks++;
    if (exp_wb_q.size() != 0 || busy_o) begin
      failures++;
      $display("FAIL %s_drain: pending=%0d busy=%0d, required 0 and 0", name, exp_wb_q.size(), busy_o);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_ni = 1'b0; flush_i = 1'b0; issue_valid_i = 1'b0; mdl_busy = 1'b0; force_pulse = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    int n, xc, wc;
    tbl[0] = '{op: DIVU,  a: 64'd100,                 b: 64'd7,                   id: 3'd3, res: 64'd14};
    tbl[1] = '{op: REM,   a: 64'hFFFF_FFFF_FFFF_FFF9, b: 64'd2,                   id: 3'd1, res: 64'hFFFF_FFFF_FFFF_FFFF};
    tbl[2] = '{op: DIV,   a: 64'd20,                  b: 64'hFFFF_FFFF_FFFF_FFFD, id: 3'd2, res: 64'hFFFF_FFFF_FFFF_FFFA};
    tbl[3] = '{op: DIVU,  a: 64'd9,                   b: 64'd0,                   id: 3'd3, res: 64'hFFFF_FFFF_FFFF_FFFF};
    tbl[4] = '{op: REMU,  a: 64'd100,                 b: 64'd7,                   id: 3'd4, res: 64'd2};
    tbl[5] = '{op: DIVW,  a: 64'h0000_0000_8000_0000, b: 64'hFFFF_FFFF_FFFF_FFFF, id: 3'd5, res: 64'hFFFF_FFFF_8000_0000};
    tbl[6] = '{op: REMUW, a: 64'hFFFF_FFFF_0000_0011, b: 64'd5,                   id: 3'd6, res: 64'd2};
    tbl[7] = '{op: REMW,  a: 64'hFFFF_FFFF_FFFF_FFF7, b: 64'd4,                   id: 3'd7, res: 64'hFFFF_FFFF_FFFF_FFFF};

    // Reset with a pending request on the issue port.
    rst_ni = 1'b0; flush_i = 1'b0; wb_ready_i = 1'b1; div_ready_i = 1'b1;
    issue_valid_i = 1'b1; issue_trans_id_i = 3'd7; issue_operator_i = REMU;
    issue_operand_a_i = 64'd55; issue_operand_b_i = 64'd3;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_issue_ready", issue_ready_o, 0);
    check("rst_div_valid", div_valid_o, 0);
    check("rst_div_a", div_operand_a_o, 0);
    check("rst_wb_valid", wb_valid_o, 0);
    check("rst_wb_result", wb_result_o, 0);
    check("rst_wb_id", wb_trans_id_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_err", protocol_err_o, 0);
    @(posedge clk); #1;
    rst_ni = 1'b1; issue_valid_i = 1'b0;
    @(negedge clk);
    check("post_rst_ready", issue_ready_o, 1);

    // Single op with latency checks.
    issue(tbl[0], tbl[0].id);
    @(negedge clk);
    check("lat_n1_div_valid", div_valid_o, 0);
    check("lat_n1_busy", busy_o, 1);
    @(negedge clk);
    check("lat_n2_div_valid", div_valid_o, 1);
    n = 0;
    do begin @(negedge clk); n++; end while (!div_valid_i && n < 50);
    check("result_pulse_seen", div_valid_i, 1);
    check("lat_m_wb_valid", wb_valid_o, 0);
    @(negedge clk);
    check("lat_m1_wb_valid", wb_valid_o, 1);
    check("single_wb_result", wb_result_o, 64'd14);
    check("single_wb_id", wb_trans_id_o, 3);
    @(negedge clk);
    check("single_busy_after", busy_o, 0);
    check("single_wb_drop", wb_valid_o, 0);

    // Table sweep; entries 1..3 fill the queue behind a stalled writeback.
    for (int i = 1; i < 8; i++) begin
      if (i == 1) begin @(posedge clk); #1 wb_ready_i = 1'b0; end
      issue(tbl[i], tbl[i].id);
      if (i == 3) begin
        repeat (10) begin
          @(negedge clk);
          check("full_issue_ready", issue_ready_o, 0);
        end
        check("full_wb_hold", wb_valid_o, 1);
        @(posedge clk); #1 wb_ready_i = 1'b1;
      end
    end
    wait_idle("table");

    // Divider holds ready low for five cycles.
    @(posedge clk); #1 div_ready_i = 1'b0;
    v = '{op: DIV, a: 64'd1000, b: 64'd10, id: 3'd2, res: 64'd100};
    issue(v, v.id);
    n = 0;
    while (!div_valid_o && n < 20) begin @(negedge clk); n++; end
    repeat (5) begin
      @(negedge clk);
      check("stall_valid", div_valid_o, 1);
      check("stall_a", div_operand_a_o, 64'd1000);
      check("stall_b", div_operand_b_o, 64'd10);
      check("stall_id", div_trans_id_o, 2);
    end
    xc = xfer_count;
    @(posedge clk); #1 div_ready_i = 1'b1;
    repeat (12) @(negedge clk);
    check("stall_one_xfer", xfer_count - xc, 1);
    wait_idle("stall");

    // Flush while id 5 is in the divider and id 4 is queued.
    div_lat = 8;
    xc = xfer_count;
    v = '{op: DIVU, a: 64'd50, b: 64'd5, id: 3'd5, res: 64'd10};
    issue(v, v.id);
    n = 0;
    while (xfer_count == xc && n < 20) begin @(negedge clk); n++; end
    check("flushw_dispatched", xfer_count - xc, 1);
    issue(tbl[4], tbl[4].id);
    flush_i = 1'b1;
    @(negedge clk);
    check("flushw_issue_ready", issue_ready_o, 0);
    @(posedge clk); #1;
    flush_i = 1'b0;
    exp_div_q.delete(); exp_wb_q.delete();
    xc = xfer_count;
    @(negedge clk);
    check("flushw_draining", busy_o, 1);
    repeat (15) @(negedge clk);
    check("flushw_idle", busy_o, 0);
    check("flushw_queue_empty", xfer_count - xc, 0);
    check("flushw_no_wb", wb_valid_o, 0);
    div_lat = 3;
    v = '{op: DIV, a: 64'd42, b: 64'd6, id: 3'd6, res: 64'd7};
    issue(v, v.id);
    wait_idle("after_flush");

    // Flush in RESP coincident with the writeback handshake.
    div_lat = 2;
    @(posedge clk); #1 wb_ready_i = 1'b0;
    issue(tbl[0], tbl[0].id);
    issue(tbl[1], tbl[1].id);
    n = 0;
    do begin @(negedge clk); n++; end while (!wb_valid_o && n < 30);
    check("flushr_wb_valid", wb_valid_o, 1);
    wc = wb_count;
    @(posedge clk); #1;
    flush_i = 1'b1; wb_ready_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    exp_div_q.delete(); exp_wb_q.delete();
    xc = xfer_count;
    repeat (8) @(negedge clk);
    check("flushr_delivered_once", wb_count - wc, 1);
    check("flushr_no_dispatch", xfer_count - xc, 0);
    check("flushr_idle", busy_o, 0);
    check("flushr_wb_low", wb_valid_o, 0);
    check("no_err_so_far", protocol_err_o, 0);

    // Protocol errors: stray pulse in IDLE, then wrong id in WAIT.
    div_lat = 3;
    @(negedge clk);
    force_pulse = 1'b1;
    @(negedge clk);
    check("err_pulse_seen", div_valid_i, 1);
    @(negedge clk);
    check("err_idle_set", protocol_err_o, 1);
    repeat (5) @(negedge clk);
    check("err_sticky", protocol_err_o, 1);
    do_reset();
    @(negedge clk);
    check("err_reset_clear", protocol_err_o, 0);
    bad_id = 1'b1;
    issue(tbl[0], tbl[0].id ^ IDW'(1));
    wait_idle("bad_id");
    bad_id = 1'b0;
    check("err_wrong_id_set", protocol_err_o, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
